// File: rtl/serial_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_link_pkg
// Purpose  : Shared types and line-level constants for the serial link blocks
//            (transmit arbiter today, receiver later).
// Revision : 1.0 - initial release
// ============================================================================
package serial_link_pkg;

    // Transmit frame sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;
    localparam logic IDLE_LEVEL           = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 5208;  // 50 MHz / 9600 baud
    localparam int   FRAME_BITS           = 10;    // start + 8 data + stop

endpackage
`default_nettype wire

// File: rtl/serial_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_arbiter_if
// Purpose  : Valid/ready character handshake for the two transmit sources
//            (req0 = Nios parallel port, req1 = receiver echo path).
// Revision : 1.0 - initial release
// ============================================================================
interface serial_tx_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    // Character sources
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready
    );
endinterface
`default_nettype wire

// File: rtl/serial_tx_arbiter_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : bit_timer
// Purpose  : Free-running bit-period counter. Held at zero while i_clear is
//            high; o_bit_end marks the last clock of each bit period.
// Revision : 1.0 - initial release
// ============================================================================
module bit_timer
    import serial_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 13
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clear,
    output logic      o_bit_end
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_bit_end = !i_clear && (r_cnt == C_LAST);

    // Count 0..CLKS_PER_BIT-1 and wrap; clear pins the count at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear || o_bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_arbiter
// Purpose  : Round-robin owner of the single outgoing serial line. Accepts one
//            character per frame from req0 or req1 and shifts it out as 8N1.
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx_arbiter
    import serial_link_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 13
) (
    input  wire logic           clk,
    input  wire logic           reset,
    serial_tx_arbiter_if.slave  req,
    output logic                tx_serial,
    output logic                busy,
    output logic                grant_id,
    output logic                frame_done
);

    localparam int         DATA_BITS  = FRAME_BITS - 2;
    localparam logic [2:0] C_LAST_IDX = 3'(DATA_BITS - 1);

    tx_state_t         r_state, w_state_next;
    logic [DATA_W-1:0] r_shift, w_shift_next;
    logic [2:0]        r_bit_idx, w_bit_idx_next;
    logic              r_last_grant, w_last_grant_next;
    logic              r_grant_id, w_grant_id_next;
    logic              r_tx, w_tx_next;
    logic              r_frame_done, w_frame_done_next;
    logic              w_ready0, w_ready1;
    logic              w_pick0, w_pick1;
    logic              w_bit_end;

    // Contention goes to whichever requester did not win last time
    assign w_pick0 = req.req0_valid && (!req.req1_valid || r_last_grant);
    assign w_pick1 = req.req1_valid && (!req.req0_valid || !r_last_grant);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (r_state == IDLE),
        .o_bit_end (w_bit_end)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, arbitration and datapath next values
    always_comb begin
        w_state_next      = r_state;
        w_shift_next      = r_shift;
        w_bit_idx_next    = r_bit_idx;
        w_last_grant_next = r_last_grant;
        w_grant_id_next   = r_grant_id;
        w_frame_done_next = 1'b0;
        w_ready0          = 1'b0;
        w_ready1          = 1'b0;
        w_tx_next         = IDLE_LEVEL;

        case (r_state)
            IDLE: begin
                if (w_pick0) begin
                    w_ready0          = 1'b1;
                    w_shift_next      = req.req0_data;
                    w_last_grant_next = 1'b0;
                    w_grant_id_next   = 1'b0;
                    w_state_next      = START;
                end else if (w_pick1) begin
                    w_ready1          = 1'b1;
                    w_shift_next      = req.req1_data;
                    w_last_grant_next = 1'b1;
                    w_grant_id_next   = 1'b1;
                    w_state_next      = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_bit_idx_next = '0;
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_idx == C_LAST_IDX) begin
                        w_bit_idx_next = '0;
                        w_state_next   = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_frame_done_next = 1'b1;
                    w_state_next      = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Line level is registered from the state being entered so the pin
        // never glitches on decode
        case (w_state_next)
            START:   w_tx_next = START_BIT;
            DATA:    w_tx_next = w_shift_next[0];
            STOP:    w_tx_next = STOP_BIT;
            default: w_tx_next = IDLE_LEVEL;
        endcase
    end

    // Datapath and output registers; reset forces the line idle immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_tx         <= IDLE_LEVEL;
            r_frame_done <= 1'b0;
        end else begin
            r_shift      <= w_shift_next;
            r_bit_idx    <= w_bit_idx_next;
            r_last_grant <= w_last_grant_next;
            r_grant_id   <= w_grant_id_next;
            r_tx         <= w_tx_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    assign req.req0_ready = w_ready0;
    assign req.req1_ready = w_ready1;
    assign tx_serial      = r_tx;
    assign busy           = (r_state != IDLE);
    assign grant_id       = r_grant_id;
    assign frame_done     = r_frame_done;

endmodule
`default_nettype wire
